// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/burst encodings and the burst-length helper shared by the arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Undefined-length bursts (SINGLE/INCR) report one beat.
    function automatic logic [4:0] hburst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  hburst_beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  hburst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: hburst_beats = 5'd16;
            default:                      hburst_beats = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: combinational round-robin search starting one past i_ptr, wrapping modulo N.
module ahb_rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    logic [IW-1:0] w_idx;

    // The pointer itself is visited last, so the current owner only wins when alone.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with registered one-hot grant and master selects.
// Define AHB_ARB_BURST_LOCK_EN to freeze the grant for the length of fixed-length bursts.
module ahb_arbiter import ahb_pkg::*; #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   hclk,
    input  logic                   hrst,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hreadyout,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_data
);

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] r_grant;
    logic [MW-1:0]          r_master;
    logic [MW-1:0]          r_master_data;

    logic [NUM_MASTERS-1:0] w_win;
    logic                   w_win_vld;
    logic [NUM_MASTERS-1:0] w_next;
    logic [MW-1:0]          w_grant_idx;
    logic                   w_owner_req;
    logic                   w_beat;
    logic                   w_arb_pt;

    // hmaster doubles as the round-robin pointer, so it resets to DEFAULT_MASTER with the outputs.
    ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
        .i_req   (hbusreq),
        .i_ptr   (r_master),
        .o_grant (w_win),
        .o_valid (w_win_vld)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) w_grant_idx = MW'(i);
        end
    end

    assign w_next      = w_win_vld ? w_win : DEF_GRANT;
    assign w_owner_req = hbusreq[r_master];
    assign w_beat      = hreadyout && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign w_arb_pt    = hreadyout && ((htrans == HTRANS_IDLE) || !w_owner_req ||
                         (w_beat && (hburst == HBURST_SINGLE || hburst == HBURST_INCR)));

`ifdef AHB_ARB_BURST_LOCK_EN
    arb_state_e r_state;
    logic [3:0] r_cnt;
    logic       w_burst_start;

    assign w_burst_start = w_beat && (htrans == HTRANS_NONSEQ) && (hburst >= HBURST_WRAP4);
`endif

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            r_grant       <= DEF_GRANT;
            r_master      <= DEF_IDX;
            r_master_data <= DEF_IDX;
`ifdef AHB_ARB_BURST_LOCK_EN
            r_state       <= ST_ARB;
            r_cnt         <= '0;
`endif
        end else begin
            if (hreadyout) r_master <= w_grant_idx;
            if (w_beat)    r_master_data <= r_master;
`ifdef AHB_ARB_BURST_LOCK_EN
            case (r_state)
                ST_ARB: begin
                    // Lock onto the master actually issuing the burst, even if a handover was pending.
                    if (w_burst_start) begin
                        r_state <= ST_BURST;
                        r_cnt   <= 4'(hburst_beats(hburst) - 5'd1);
                        r_grant <= NUM_MASTERS'(1) << r_master;
                    end else if (w_arb_pt) begin
                        r_grant <= w_next;
                    end
                end
                ST_BURST: begin
                    if (hreadyout && htrans == HTRANS_SEQ) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt <= 4'd1) begin
                            r_state <= ST_ARB;
                            r_grant <= w_next;
                        end
                    end else if (hreadyout && htrans == HTRANS_IDLE) begin
                        // Early termination by the owner releases the lock.
                        r_state <= ST_ARB;
                        r_cnt   <= '0;
                        r_grant <= w_next;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
`else
            if (w_arb_pt) r_grant <= w_next;
`endif
        end
    end

    assign hgrant       = r_grant;
    assign hmaster      = r_master;
    assign hmaster_data = r_master_data;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: scoreboard bench for ahb_arbiter with 4 masters and DEFAULT_MASTER=0.
module tb_ahb_arbiter;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;
`ifdef AHB_ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] m;
        logic [1:0] md;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        exp_t       e;
    } row_t;

    logic       hclk;
    logic       hrst;
    logic [3:0] hbusreq;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hreadyout;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .hclk         (hclk),
        .hrst         (hrst),
        .hbusreq      (hbusreq),
        .htrans       (htrans),
        .hburst       (hburst),
        .hreadyout    (hreadyout),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "time limit expired");
    end

    function automatic row_t mk(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                                input logic rdy, input logic [3:0] g, input logic [1:0] m,
                                input logic [1:0] md);
        row_t r;
        r.req  = req;
        r.tr   = tr;
        r.bu   = bu;
        r.rdy  = rdy;
        r.e.g  = g;
        r.e.m  = m;
        r.e.md = md;
        return r;
    endfunction

    // Drive one cycle of inputs, queue its expected post-edge outputs, sample 1ns after the edge.
    task automatic drive_cycle(input row_t r);
        hbusreq   = r.req;
        htrans    = r.tr;
        hburst    = r.bu;
        hreadyout = r.rdy;
        sb.push_back(r.e);
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        hrst      = 1'b1;
        hbusreq   = 4'b1111;
        htrans    = T_NONSEQ;
        hburst    = B_INCR4;
        hreadyout = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_t'{4'b0001, 2'd0, 2'd0});
            @(posedge hclk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({hgrant, hmaster, hmaster_data} !== e) begin
                errors++;
                $display("FAIL reset[%0d] got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                         i, hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
            end
        end
        hrst = 1'b0;
    endtask

    task automatic test_single();
        row_t rows [6];
        exp_t e;
        rows = '{mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd0, 2'd0),
                 mk(4'b0100, T_IDLE,   B_SINGLE, 1'b0, 4'b0100, 2'd0, 2'd0),
                 mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0),
                 mk(4'b0100, T_NONSEQ, B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd2, 2'd2),
                 mk(4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd2)};
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({hgrant, hmaster, hmaster_data} !== e) begin
                errors++;
                $display("FAIL single[%0d] got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                         i, hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
            end
        end
    endtask

    // Every master requests; each owner issues one SINGLE then goes IDLE.
    task automatic test_fairness();
        row_t rows [10];
        exp_t e;
        rows = '{mk(4'b1111, T_IDLE,   B_SINGLE, 1'b1, 4'b0010, 2'd0, 2'd2),
                 mk(4'b1111, T_IDLE,   B_SINGLE, 1'b1, 4'b0010, 2'd1, 2'd2),
                 mk(4'b1111, T_NONSEQ, B_SINGLE, 1'b1, 4'b0100, 2'd1, 2'd1),
                 mk(4'b1111, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd1),
                 mk(4'b1111, T_NONSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd2, 2'd2),
                 mk(4'b1111, T_IDLE,   B_SINGLE, 1'b1, 4'b1000, 2'd3, 2'd2),
                 mk(4'b1111, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd3, 2'd3),
                 mk(4'b1111, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd3),
                 mk(4'b1111, T_NONSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd0, 2'd0),
                 mk(4'b1111, T_IDLE,   B_SINGLE, 1'b1, 4'b0010, 2'd1, 2'd0)};
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({hgrant, hmaster, hmaster_data} !== e) begin
                errors++;
                $display("FAIL fairness[%0d] got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                         i, hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
            end
        end
    endtask

    // Owner drops and a transient request appears while the slave stalls; nothing moves until ready.
    task automatic test_wait();
        row_t rows [4];
        exp_t e;
        rows = '{mk(4'b1000, T_IDLE, B_SINGLE, 1'b0, 4'b0010, 2'd1, 2'd0),
                 mk(4'b0000, T_IDLE, B_SINGLE, 1'b0, 4'b0010, 2'd1, 2'd0),
                 mk(4'b0000, T_IDLE, B_SINGLE, 1'b1, 4'b0001, 2'd1, 2'd0),
                 mk(4'b0000, T_IDLE, B_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0)};
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({hgrant, hmaster, hmaster_data} !== e) begin
                errors++;
                $display("FAIL wait[%0d] got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                         i, hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
            end
        end
    endtask

    // Master 2 INCR4 with master 3 waiting, two stall cycles after beat 2.
    task automatic test_burst();
        row_t rows [9];
        exp_t e;
        rows = '{mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd0, 2'd0),
                 mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0),
                 mk(4'b1100, T_NONSEQ, B_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1100, T_SEQ,    B_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1100, T_SEQ,    B_INCR4,  1'b0, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1100, T_SEQ,    B_INCR4,  1'b0, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1100, T_SEQ,    B_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1000, T_SEQ,    B_INCR4,  1'b1, 4'b1000, 2'd2, 2'd2),
                 mk(4'b1000, T_IDLE,   B_INCR4,  1'b1, 4'b1000, 2'd3, 2'd2)};
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({hgrant, hmaster, hmaster_data} !== e) begin
                errors++;
                $display("FAIL burst[%0d] got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                         i, hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
            end
        end
    endtask

    // Master 2 drops its request after beat 1: lock keeps the grant, otherwise it moves at once.
    task automatic test_burst_drop();
        row_t rows [8];
        exp_t e;
        rows = '{mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd3, 2'd2),
                 mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1100, T_NONSEQ, B_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1000, T_SEQ,    B_INCR4,  1'b1, LOCK ? 4'b0100 : 4'b1000, 2'd2, 2'd2),
                 mk(4'b1000, T_SEQ,    B_INCR4,  1'b1, LOCK ? 4'b0100 : 4'b1000, LOCK ? 2'd2 : 2'd3, 2'd2),
                 mk(4'b1000, T_SEQ,    B_INCR4,  1'b1, 4'b1000, LOCK ? 2'd2 : 2'd3, LOCK ? 2'd2 : 2'd3),
                 mk(4'b1000, T_IDLE,   B_INCR4,  1'b1, 4'b1000, 2'd3, LOCK ? 2'd2 : 2'd3),
                 mk(4'b1000, T_NONSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd3, 2'd3)};
        foreach (rows[i]) begin
            drive_cycle(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({hgrant, hmaster, hmaster_data} !== e) begin
                errors++;
                $display("FAIL burst_drop[%0d] got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                         i, hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
            end
        end
    endtask

    // Reset lands mid-cycle during beat 3 of an INCR8, then a fresh INCR4 must count four beats.
    task automatic test_mid_reset();
        row_t pre [4];
        row_t post [7];
        exp_t e;
        pre  = '{mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd3, 2'd3),
                 mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd3),
                 mk(4'b0110, T_NONSEQ, B_INCR8,  1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b0110, T_SEQ,    B_INCR8,  1'b1, 4'b0100, 2'd2, 2'd2)};
        post = '{mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd0, 2'd0),
                 mk(4'b0100, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0),
                 mk(4'b1100, T_NONSEQ, B_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1100, T_SEQ,    B_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1100, T_SEQ,    B_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2),
                 mk(4'b1100, T_SEQ,    B_INCR4,  1'b1, LOCK ? 4'b1000 : 4'b0100, 2'd2, 2'd2),
                 mk(4'b1000, T_IDLE,   B_INCR4,  1'b1, 4'b1000, LOCK ? 2'd3 : 2'd2, 2'd2)};
        foreach (pre[i]) begin
            drive_cycle(pre[i]);
            e = sb.pop_front();
            checks++;
            if ({hgrant, hmaster, hmaster_data} !== e) begin
                errors++;
                $display("FAIL midrst_pre[%0d] got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                         i, hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
            end
        end
        hbusreq   = 4'b0110;
        htrans    = T_SEQ;
        hburst    = B_INCR8;
        hreadyout = 1'b1;
        #2;
        hrst = 1'b1;
        sb.push_back(exp_t'{4'b0001, 2'd0, 2'd0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({hgrant, hmaster, hmaster_data} !== e) begin
            errors++;
            $display("FAIL midrst_async got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                     hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
        end
        sb.push_back(exp_t'{4'b0001, 2'd0, 2'd0});
        @(posedge hclk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({hgrant, hmaster, hmaster_data} !== e) begin
            errors++;
            $display("FAIL midrst_hold got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                     hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
        end
        hrst = 1'b0;
        foreach (post[i]) begin
            drive_cycle(post[i]);
            e = sb.pop_front();
            checks++;
            if ({hgrant, hmaster, hmaster_data} !== e) begin
                errors++;
                $display("FAIL midrst_post[%0d] got grant=%b master=%0d mdata=%0d want grant=%b master=%0d mdata=%0d",
                         i, hgrant, hmaster, hmaster_data, e.g, e.m, e.md);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wait();
        test_burst();
        test_burst_drop();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of requesting masters, range 2..8.
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0: master that parks the bus when nobody requests.
REQ-003 SHALL have port hclk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port hrst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port hbusreq, input, NUM_MASTERS: per-master bus request.
REQ-006 SHALL have port htrans, input, 2: transfer type of the master that currently owns the address phase.
REQ-007 SHALL have port hburst, input, 3: burst type of the address-phase owner.
REQ-008 SHALL have port hreadyout, input, 1: slave ready; a beat is accepted when this is 1.
REQ-009 SHALL have port hgrant, output, NUM_MASTERS: one-hot grant.
REQ-010 SHALL have port hmaster, output, clog2(NUM_MASTERS): index of the address-phase owner, used as the address/control mux select.
REQ-011 SHALL have port hmaster_data, output, clog2(NUM_MASTERS): index of the data-phase owner, used as the hwdata mux select.

Function
REQ-012 SHALL arbitrate round-robin; the search SHALL start at hmaster+1 and wrap modulo NUM_MASTERS.
REQ-013 SHALL use two states: ARB (rearbitration allowed) and BURST (grant frozen).
REQ-014 In ARB, a rearbitration point SHALL occur on a cycle with hreadyout=1 where htrans=IDLE, or the owner's hbusreq=0, or a SINGLE/INCR beat is accepted.
REQ-015 At a rearbitration point, hgrant SHALL be registered to the round-robin winner, updating one cycle later.
REQ-016 When no master requests at a rearbitration point, hgrant SHALL go to DEFAULT_MASTER.
REQ-017 hmaster SHALL load the granted index on every cycle where hreadyout=1; it SHALL hold while hreadyout=0.
REQ-018 hmaster_data SHALL load hmaster on every cycle where htrans is NONSEQ or SEQ and hreadyout=1; it SHALL hold otherwise.
REQ-019 hgrant SHALL stay exactly one-hot at all times, including while hreadyout=0.
REQ-020 A grant change requested while hreadyout=0 SHALL take effect only once hreadyout=1.
REQ-021 When a master asserts and drops hbusreq in the same cycle as a rearbitration point, only the sampled value SHALL count; there is no request latching.

Reset
REQ-022 While hrst=1, outputs SHALL be: hgrant=one-hot(DEFAULT_MASTER), hmaster=DEFAULT_MASTER, hmaster_data=DEFAULT_MASTER.
REQ-023 While hrst=1, internal state SHALL be: state=ARB, beat counter=0, round-robin pointer=DEFAULT_MASTER.
REQ-024 Reset asserted mid-burst SHALL abandon the burst immediately, without waiting for a clock edge.

Configuration
REQ-025 Macro AHB_ARB_BURST_LOCK_EN defined: a NONSEQ accepted with hburst in 2..7 SHALL enter BURST.
REQ-026 With AHB_ARB_BURST_LOCK_EN, the beat counter SHALL load beats-1 on entry: 3 for hburst 2/3, 7 for 4/5, 15 for 6/7.
REQ-027 With AHB_ARB_BURST_LOCK_EN, the counter SHALL decrement per accepted SEQ and hold on BUSY or hreadyout=0.
REQ-028 With AHB_ARB_BURST_LOCK_EN, acceptance of the last beat (counter=0) SHALL be a rearbitration point; hbusreq changes SHALL be ignored during BURST.
REQ-029 Macro AHB_ARB_BURST_LOCK_EN undefined: no BURST state and no counter; fixed bursts SHALL follow the REQ-014 rules.

Structure
REQ-030 The shared package ahb_pkg SHALL hold the htrans encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), the hburst encodings, and a beats-per-hburst function.
REQ-031 Round-robin selection SHALL live in a combinational sub-module ahb_rr_picker (inputs: request vector, pointer; output: one-hot winner plus a valid flag).

Verification
REQ-032 Reset: hrst=1 with hbusreq=4'b1111 -> hgrant=4'b0001, hmaster=0, hmaster_data=0.
REQ-033 Single request: hbusreq=4'b0100 with the bus idle -> hgrant=4'b0100 next cycle, then hmaster=2 on the next hreadyout=1 cycle.
REQ-034 Fairness: hbusreq=4'b1111, each owner does one SINGLE then IDLE -> grant order 1,2,3,0,1.
REQ-035 Burst lock (macro on): master 2 INCR4 with master 3 requesting, hreadyout=0 for 2 cycles after beat 2 -> hgrant stays 4'b0100 until beat 4 is accepted, then 4'b1000.
REQ-036 Burst lock (macro off), same stimulus with master 2 dropping hbusreq after beat 1 -> grant moves to master 3 after beat 1.
REQ-037 Mid-burst reset: hrst pulsed during beat 3 of INCR8 -> outputs return to their reset values at once; the first post-reset NONSEQ starts a fresh count.
